multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Main control FSM for the RISC-V multi-cycle processor; replaces the combinational-only ImmSrc decode with a full sequenced controller.
- Steps each instruction through Fetch/Decode/Execute/Writeback states.
- Waits on a memory-ready handshake and generates every datapath enable and mux select, including a widened 3-bit ImmSrc.
- Parametrised to optionally support JALR, U-type (LUI/AUIPC) and illegal-opcode trapping.

Parameters:
- SUPPORT_JALR, 1, 1 enables opcode 1100111 path; 0 treats it as unsupported.
- SUPPORT_UTYPE, 1, 1 enables LUI 0110111 and AUIPC 0010111; 0 treats them as unsupported.
- TRAP_ON_ILLEGAL, 1, 1 sends unsupported opcodes to sticky TRAP; 0 returns to FETCH (NOP).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  opcode field of the instruction register.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory access complete this cycle.
- PCWrite  out  1  PC load enable; equals PCUpdate OR (Branch AND Zero).
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction register / OldPC load.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct-decoded.
- ImmSrc  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- RegWrite  out  1  register file write enable.
- Illegal  out  1  sticky illegal-instruction flag.
- State  out  4  current state encoding, for debug.

Behaviour:
- Moore FSM; state register is the only storage. Async reset -> state FETCH.
- While reset is high, PCWrite, MemWrite, IRWrite and RegWrite are forced 0; Illegal = 0.
- ImmSrc is combinational from op in every state: 0000011/0010011/1100111 -> 000, 0100011 -> 001, 1100011 -> 010, 1101111 -> 011, 0110111/0010111 -> 100 (when SUPPORT_UTYPE), otherwise 000.
- All selects not listed for a state are 00 and all enables not listed are 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, JALRADR=11, LUI=12, AUIPC=13, TRAP=15.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00. IRWrite=PCUpdate=MemReady. Stay while MemReady=0; go to DECODE on MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut). Next state by op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 1100111 -> JALRADR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - disabled or unknown opcodes -> TRAP or FETCH per TRAP_ON_ILLEGAL.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady=1, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until MemReady=1, then -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; -> ALUWB (writes OldPC+4).
- JALRADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; -> JAL (ALUOut then holds rs1+imm).
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00; -> ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00; -> ALUWB.
- TRAP: Illegal=1, all enables 0; remains in TRAP until reset.
- Latency (cycles, MemReady always 1): lw 5, sw 4, R/I 4, beq 3, jal 4, jalr 5, lui/auipc 4. Each wait cycle on MemReady adds 1.
- Reset asserted mid-instruction: immediate return to FETCH; no partial write may occur in the reset cycle.

Test Plan:
- Reset for 2 cycles, then op=0000011 with MemReady low for 2 cycles in both FETCH and MEMREAD -> States 0,0,0,1,2,3,3,3,4,0; RegWrite=1 only in state 4; total 9 cycles.
- sw (op=0100011), MemReady=1 -> States 0,1,2,5; MemWrite=1 for exactly 1 cycle; ImmSrc=001.
- beq with Zero=1, then repeated with Zero=0 -> PCWrite=1 in BEQ only when Zero=1; ALUOp=01; ImmSrc=010.
- jalr (1100111), SUPPORT_JALR=1 -> States 0,1,11,10,8; PCWrite=1 in state 10; RegWrite=1 in state 8.
- lui (0110111), SUPPORT_UTYPE=0 and TRAP_ON_ILLEGAL=1 -> State 15, Illegal=1 sticky across 10 cycles; reset clears to State 0, Illegal=0.
- Assert reset during MEMWRITE with MemReady=0 -> MemWrite drops to 0 in the same cycle; State=0 on release.

Source files
------------

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multi-cycle main FSM (master) and the datapath (slave).
// The datapath drives the opcode and status flags; the FSM drives every enable and select.
interface multicycle_main_fsm_if;
    logic [6:0] op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       RegWrite;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  op, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, Illegal, State
    );

    modport slave (
        output op, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, Illegal, State
    );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main sequencing controller for the RV32 multi-cycle core: a Moore FSM stepping each
// instruction through fetch/decode/execute/writeback and producing all datapath controls.
module multicycle_main_fsm #(
    parameter bit SUPPORT_JALR    = 1'b1,
    parameter bit SUPPORT_UTYPE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_main_fsm_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        JALRADR  = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam state_t ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? TRAP : FETCH;

    state_t     state_q;
    state_t     state_d;
    logic       pc_update_s;
    logic       branch_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [2:0] imm_src_s;

    // State register: the only storage in the controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Immediate format decode, independent of the current state.
    always_comb begin
        imm_src_s = 3'b000;
        case (bus.op)
            OP_SW:    imm_src_s = 3'b001;
            OP_BEQ:   imm_src_s = 3'b010;
            OP_JAL:   imm_src_s = 3'b011;
            OP_LUI, OP_AUIPC: begin
                if (SUPPORT_UTYPE) begin
                    imm_src_s = 3'b100;
                end else begin
                    imm_src_s = 3'b000;
                end
            end
            default:  imm_src_s = 3'b000;
        endcase
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_d      = state_q;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        case (state_q)
            FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = bus.MemReady;
                pc_update_s  = bus.MemReady;
                if (bus.MemReady) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                // OldPC + imm lands in ALUOut so BEQ/JAL can use it as their target.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    OP_JALR:      state_d = SUPPORT_JALR  ? JALRADR : ILLEGAL_NEXT;
                    OP_LUI:       state_d = SUPPORT_UTYPE ? LUI     : ILLEGAL_NEXT;
                    OP_AUIPC:     state_d = SUPPORT_UTYPE ? AUIPC   : ILLEGAL_NEXT;
                    default:      state_d = ILLEGAL_NEXT;
                endcase
            end
            MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (bus.op == OP_LW) begin
                    state_d = MEMREAD;
                end else begin
                    state_d = MEMWRITE;
                end
            end
            MEMREAD: begin
                adr_src_s = 1'b1;
                if (bus.MemReady) begin
                    state_d = MEMWB;
                end else begin
                    state_d = MEMREAD;
                end
            end
            MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (bus.MemReady) begin
                    state_d = FETCH;
                end else begin
                    state_d = MEMWRITE;
                end
            end
            EXECR: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
                state_d     = ALUWB;
            end
            EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                state_d     = FETCH;
            end
            BEQ: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                branch_s    = 1'b1;
                state_d     = FETCH;
            end
            JAL: begin
                // PC takes ALUOut while ALUResult forms OldPC + 4 for the link write.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
                state_d     = ALUWB;
            end
            JALRADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                state_d     = JAL;
            end
            LUI: begin
                alu_src_a_s = 2'b11;
                alu_src_b_s = 2'b01;
                state_d     = ALUWB;
            end
            AUIPC: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                state_d     = ALUWB;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Write enables are gated by reset so nothing commits in a reset cycle.
    assign bus.PCWrite   = ~reset & (pc_update_s | (branch_s & bus.Zero));
    assign bus.MemWrite  = ~reset & mem_write_s;
    assign bus.IRWrite   = ~reset & ir_write_s;
    assign bus.RegWrite  = ~reset & reg_write_s;
    assign bus.Illegal   = ~reset & (state_q == TRAP);
    assign bus.AdrSrc    = adr_src_s;
    assign bus.ResultSrc = result_src_s;
    assign bus.ALUSrcA   = alu_src_a_s;
    assign bus.ALUSrcB   = alu_src_b_s;
    assign bus.ALUOp     = alu_op_s;
    assign bus.ImmSrc    = imm_src_s;
    assign bus.State     = state_q;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: three parameter variants, each instruction
// modelled as a list of phases walked cycle by cycle against a per-phase control table.
module tb_multicycle_main_fsm;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       reset_s;
    logic [6:0] op_s;
    logic       zero_s;
    logic       ready_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm_if bus0 ();
    multicycle_main_fsm_if bus1 ();
    multicycle_main_fsm_if bus2 ();

    assign bus0.op = op_s;  assign bus0.Zero = zero_s;  assign bus0.MemReady = ready_s;
    assign bus1.op = op_s;  assign bus1.Zero = zero_s;  assign bus1.MemReady = ready_s;
    assign bus2.op = op_s;  assign bus2.Zero = zero_s;  assign bus2.MemReady = ready_s;

    multicycle_main_fsm #(.SUPPORT_JALR(1'b1), .SUPPORT_UTYPE(1'b1), .TRAP_ON_ILLEGAL(1'b1))
        dut0 (.clk(clk), .reset(reset_s), .bus(bus0));
    multicycle_main_fsm #(.SUPPORT_JALR(1'b1), .SUPPORT_UTYPE(1'b0), .TRAP_ON_ILLEGAL(1'b1))
        dut1 (.clk(clk), .reset(reset_s), .bus(bus1));
    multicycle_main_fsm #(.SUPPORT_JALR(1'b0), .SUPPORT_UTYPE(1'b0), .TRAP_ON_ILLEGAL(1'b0))
        dut2 (.clk(clk), .reset(reset_s), .bus(bus2));

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, Illegal, State}
    logic [20:0] obs [3];
    assign obs[0] = {bus0.PCWrite, bus0.AdrSrc, bus0.MemWrite, bus0.IRWrite, bus0.ResultSrc, bus0.ALUSrcA,
                     bus0.ALUSrcB, bus0.ALUOp, bus0.ImmSrc, bus0.RegWrite, bus0.Illegal, bus0.State};
    assign obs[1] = {bus1.PCWrite, bus1.AdrSrc, bus1.MemWrite, bus1.IRWrite, bus1.ResultSrc, bus1.ALUSrcA,
                     bus1.ALUSrcB, bus1.ALUOp, bus1.ImmSrc, bus1.RegWrite, bus1.Illegal, bus1.State};
    assign obs[2] = {bus2.PCWrite, bus2.AdrSrc, bus2.MemWrite, bus2.IRWrite, bus2.ResultSrc, bus2.ALUSrcA,
                     bus2.ALUSrcB, bus2.ALUOp, bus2.ImmSrc, bus2.RegWrite, bus2.Illegal, bus2.State};

    function automatic bit jalr_en(int inst);  return inst != 2; endfunction
    function automatic bit utype_en(int inst); return inst == 0; endfunction
    function automatic bit trap_en(int inst);  return inst != 2; endfunction

    // Phase list of one instruction; FETCH (0), MEMREAD (3) and MEMWRITE (5) wait on MemReady.
    int plan[$];
    function automatic void build_plan(int inst, logic [6:0] opc);
        bit legal;
        legal = 1'b1;
        plan.delete();
        case (opc)
            OP_LW:    plan = '{0, 1, 2, 3, 4};
            OP_SW:    plan = '{0, 1, 2, 5};
            OP_R:     plan = '{0, 1, 6, 8};
            OP_I:     plan = '{0, 1, 7, 8};
            OP_BEQ:   plan = '{0, 1, 9};
            OP_JAL:   plan = '{0, 1, 10, 8};
            OP_JALR:  if (jalr_en(inst))  plan = '{0, 1, 11, 10, 8}; else legal = 1'b0;
            OP_LUI:   if (utype_en(inst)) plan = '{0, 1, 12, 8};     else legal = 1'b0;
            OP_AUIPC: if (utype_en(inst)) plan = '{0, 1, 13, 8};     else legal = 1'b0;
            default:  legal = 1'b0;
        endcase
        if (!legal) begin
            plan = '{0, 1};
            if (trap_en(inst)) plan.push_back(15);
        end
    endfunction

    function automatic logic [2:0] imm_of(int inst, logic [6:0] opc);
        case (opc)
            OP_SW:            return 3'b001;
            OP_BEQ:           return 3'b010;
            OP_JAL:           return 3'b011;
            OP_LUI, OP_AUIPC: return utype_en(inst) ? 3'b100 : 3'b000;
            default:          return 3'b000;
        endcase
    endfunction

    // Control table by phase number, as listed for the processor's controller.
    function automatic logic [20:0] exp_word(int inst, int st, logic [6:0] opc, logic z, logic rdy, logic rst);
        logic pcu, br, adr, mw, irw, rw, ill, pcw;
        logic [1:0] rs, a, b, aop;
        int s;
        pcu = 1'b0; br = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
        rs = 2'd0; a = 2'd0; b = 2'd0; aop = 2'd0;
        s = rst ? 0 : st;
        case (s)
            0:  begin b = 2'd2; rs = 2'd2; irw = rdy; pcu = rdy; end
            1:  begin a = 2'd1; b = 2'd1; end
            2:  begin a = 2'd2; b = 2'd1; end
            3:  begin adr = 1'b1; end
            4:  begin rs = 2'd1; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin a = 2'd2; aop = 2'd2; end
            7:  begin a = 2'd2; b = 2'd1; aop = 2'd2; end
            8:  begin rw = 1'b1; end
            9:  begin a = 2'd2; aop = 2'd1; br = 1'b1; end
            10: begin a = 2'd1; b = 2'd2; pcu = 1'b1; end
            11: begin a = 2'd2; b = 2'd1; end
            12: begin a = 2'd3; b = 2'd1; end
            13: begin a = 2'd1; b = 2'd1; end
            15: begin ill = 1'b1; end
            default: ;
        endcase
        pcw = pcu | (br & z);
        if (rst) begin
            pcw = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
        end
        return {pcw, adr, mw, irw, rs, a, b, aop, imm_of(inst, opc), rw, ill, s[3:0]};
    endfunction

    int rdy_plan[$];
    int zero_fix  = -1;
    int ready_pct = 100;
    int seen_states[$];
    int cnt_mw, cnt_pcw, cnt_rw;

    // Walks one instruction on instance inst; called at posedge+1, returns at posedge+1.
    task automatic run_instr(int inst, logic [6:0] opc, int hold);
        logic [20:0] exp;
        int guard;
        op_s = opc;
        build_plan(inst, opc);
        seen_states.delete();
        cnt_mw = 0; cnt_pcw = 0; cnt_rw = 0;
        foreach (plan[k]) begin
            guard = 0;
            forever begin
                if (rdy_plan.size() > 0) ready_s = rdy_plan.pop_front() != 0;
                else ready_s = (guard >= 6) ? 1'b1 : ($urandom_range(99) < ready_pct);
                zero_s = (zero_fix < 0) ? 1'($urandom_range(1)) : (zero_fix != 0);
                @(negedge clk);
                exp = exp_word(inst, plan[k], opc, zero_s, ready_s, reset_s);
                n_checks++;
                if (obs[inst] !== exp) begin
                    n_fail++;
                    $display("FAIL phase inst=%0d op=%b phase=%0d rdy=%b zero=%b: got %h expected %h",
                             inst, opc, plan[k], ready_s, zero_s, obs[inst], exp);
                end
                seen_states.push_back(int'(obs[inst][3:0]));
                cnt_pcw += int'(obs[inst][20]);
                cnt_mw  += int'(obs[inst][18]);
                cnt_rw  += int'(obs[inst][5]);
                @(posedge clk); #1;
                guard++;
                if (plan[k] == 15) begin
                    if (guard >= hold) break;
                end else if (!(plan[k] == 0 || plan[k] == 3 || plan[k] == 5) || ready_s) begin
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_s = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset_s = 1'b0;
    endtask

    task automatic test_reset();
        logic [20:0] exp;
        reset_s = 1'b1;
        ready_s = 1'b1;
        zero_s  = 1'b1;
        op_s    = OP_LUI;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                exp = exp_word(i, 0, op_s, zero_s, ready_s, 1'b1);
                n_checks++;
                if (obs[i] !== exp) begin
                    n_fail++;
                    $display("FAIL reset inst=%0d: got %h expected %h", i, obs[i], exp);
                end
            end
            @(posedge clk); #1;
        end
        reset_s = 1'b0;
    endtask

    task automatic test_lw_wait();
        int exp_seq[$];
        int bad;
        exp_seq = '{0, 0, 0, 1, 2, 3, 3, 3, 4};
        rdy_plan = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
        run_instr(0, OP_LW, 1);
        bad = (seen_states.size() != exp_seq.size()) ? 1 : 0;
        if (bad == 0) foreach (exp_seq[k]) if (seen_states[k] != exp_seq[k]) bad = 1;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL lw_seq: got %0d cycles %p expected %p", seen_states.size(), seen_states, exp_seq);
        end
        n_checks++;
        if (cnt_rw != 1) begin
            n_fail++;
            $display("FAIL lw_regwrite: got %0d cycles expected 1", cnt_rw);
        end
    endtask

    task automatic test_sw();
        ready_pct = 100;
        run_instr(0, OP_SW, 1);
        n_checks++;
        if (cnt_mw != 1 || seen_states.size() != 4) begin
            n_fail++;
            $display("FAIL sw: got memwrite=%0d latency=%0d expected 1 and 4", cnt_mw, seen_states.size());
        end
    endtask

    task automatic test_beq();
        ready_pct = 100;
        zero_fix  = 1;
        run_instr(0, OP_BEQ, 1);
        n_checks++;
        if (cnt_pcw != 2 || seen_states.size() != 3) begin
            n_fail++;
            $display("FAIL beq_taken: got pcwrite=%0d latency=%0d expected 2 and 3", cnt_pcw, seen_states.size());
        end
        zero_fix = 0;
        run_instr(0, OP_BEQ, 1);
        n_checks++;
        if (cnt_pcw != 1) begin
            n_fail++;
            $display("FAIL beq_not_taken: got pcwrite=%0d expected 1", cnt_pcw);
        end
        zero_fix = -1;
    endtask

    task automatic test_jalr();
        ready_pct = 100;
        run_instr(0, OP_JALR, 1);
        n_checks++;
        if (seen_states.size() != 5 || cnt_pcw != 2 || cnt_rw != 1) begin
            n_fail++;
            $display("FAIL jalr: got latency=%0d pcwrite=%0d regwrite=%0d expected 5 2 1",
                     seen_states.size(), cnt_pcw, cnt_rw);
        end
    endtask

    task automatic test_trap();
        logic [20:0] exp;
        do_reset();
        ready_pct = 100;
        run_instr(1, OP_LUI, 10);
        reset_s = 1'b1;
        @(negedge clk);
        exp = exp_word(1, 0, op_s, zero_s, ready_s, 1'b1);
        n_checks++;
        if (obs[1] !== exp) begin
            n_fail++;
            $display("FAIL trap_reset: got %h expected %h", obs[1], exp);
        end
        @(posedge clk); #1;
        reset_s = 1'b0;
        ready_s = 1'b0;
        @(negedge clk);
        exp = exp_word(1, 0, op_s, zero_s, 1'b0, 1'b0);
        n_checks++;
        if (obs[1] !== exp) begin
            n_fail++;
            $display("FAIL trap_release: got %h expected %h", obs[1], exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nop_variant();
        do_reset();
        ready_pct = 60;
        run_instr(2, OP_LUI, 1);
        run_instr(2, OP_JALR, 1);
        run_instr(2, 7'b1111111, 1);
        run_instr(2, OP_R, 1);
        n_checks++;
        if (seen_states.size() < 4 || seen_states[seen_states.size() - 1] != 8) begin
            n_fail++;
            $display("FAIL nop_resume: got %0d cycles expected R-type to reach ALUWB", seen_states.size());
        end
    endtask

    task automatic test_reset_memwrite();
        do_reset();
        op_s    = OP_SW;
        ready_s = 1'b1;
        zero_s  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready_s = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus0.MemWrite !== 1'b1 || bus0.State !== 4'd5) begin
            n_fail++;
            $display("FAIL memwrite_hold: got mw=%b state=%0d expected 1 and 5", bus0.MemWrite, bus0.State);
        end
        #1 reset_s = 1'b1;
        #1;
        n_checks++;
        if (bus0.MemWrite !== 1'b0 || bus0.State !== 4'd0) begin
            n_fail++;
            $display("FAIL memwrite_reset: got mw=%b state=%0d expected 0 and 0", bus0.MemWrite, bus0.State);
        end
        @(posedge clk); #1;
        reset_s = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus0.State !== 4'd0 || bus0.MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL memwrite_release: got state=%0d mw=%b expected 0 and 0", bus0.State, bus0.MemWrite);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [6:0] ops [12];
        logic [6:0] opc;
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
                7'b0000000, 7'b1111111, 7'b0001111};
        do_reset();
        ready_pct = 70;
        zero_fix  = -1;
        for (int n = 0; n < 40; n++) begin
            opc = ops[$urandom_range(11)];
            run_instr(0, opc, 3);
            if (plan[plan.size() - 1] == 15) do_reset();
        end
    endtask

    initial begin
        reset_s = 1'b1;
        op_s    = 7'd0;
        zero_s  = 1'b0;
        ready_s = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_lw_wait();
        test_sw();
        test_beq();
        test_jalr();
        test_trap();
        test_nop_variant();
        test_reset_memwrite();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
